// File: rtl/serial_adder_nbit.sv
// rtl/serial_adder_nbit.sv - bit-serial adder/subtractor, one full-adder slice reused LSB first
module serial_adder_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] z,
    output logic             r,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_c;
    logic [CW-1:0]    r_cnt;

    logic             w_sum;
    logic             w_cout;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_res_next;

    assign w_sum      = r_a[0] ^ r_b[0] ^ r_c;
    assign w_cout     = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_accept   = start && (r_state == S_IDLE || r_state == S_DONE);
    // Shifting through a WIDTH+1 vector keeps the MSB insert legal for WIDTH=1.
    assign w_shift    = {w_sum, r_res};
    assign w_res_next = w_shift[WIDTH:1];

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_RUN : S_IDLE;
            S_RUN:   w_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            z       <= '0;
            r       <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a   <= x;
                r_b   <= y ^ {WIDTH{sub}};
                r_c   <= cin ^ sub;
                r_res <= '0;
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_res <= w_res_next;
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_c   <= w_cout;
                r_cnt <= r_cnt + 1'b1;
                // On the last bit r_c is the carry into the MSB, so its XOR with
                // the carry out is the signed overflow.
                if (w_last) begin
                    z   <= w_res_next;
                    r   <= w_cout;
                    ovf <= r_c ^ w_cout;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_nbit.sv
// tb/tb_serial_adder_nbit.sv - randomized self-checking bench for serial_adder_nbit
module tb_serial_adder_nbit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic        start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
    logic [7:0]  x8 = '0, y8 = '0, z8;
    logic        r8, ovf8, busy8, done8;

    logic        start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
    logic [0:0]  x1 = '0, y1 = '0, z1;
    logic        r1, ovf1, busy1, done1;

    logic        start16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
    logic [15:0] x16 = '0, y16 = '0, z16;
    logic        r16, ovf16, busy16, done16;

    serial_adder_nbit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .x(x8), .y(y8), .cin(cin8),
        .z(z8), .r(r8), .ovf(ovf8), .busy(busy8), .done(done8)
    );
    serial_adder_nbit #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .x(x1), .y(y1), .cin(cin1),
        .z(z1), .r(r1), .ovf(ovf1), .busy(busy1), .done(done1)
    );
    serial_adder_nbit #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .x(x16), .y(y16), .cin(cin16),
        .z(z16), .r(r16), .ovf(ovf16), .busy(busy16), .done(done16)
    );

    // Arithmetic reference: unsigned result modulo 2^w, carry/no-borrow, signed range check.
    function automatic void ref_model(input int w, input longint xv, input longint yv,
                                      input bit s, input bit ci,
                                      output longint zv, output bit rv, output bit ov);
        longint m, sx, sy, ss, tot;
        m   = longint'(1) << w;
        sx  = (xv >= m / 2) ? xv - m : xv;
        sy  = (yv >= m / 2) ? yv - m : yv;
        if (!s) begin
            tot = xv + yv + longint'(ci);
            rv  = (tot >= m);
            ss  = sx + sy + longint'(ci);
        end else begin
            tot = xv - yv - longint'(ci);
            rv  = (xv >= yv + longint'(ci));
            ss  = sx - sy - longint'(ci);
        end
        zv = ((tot % m) + m) % m;
        ov = (ss >= m / 2) || (ss < -(m / 2));
    endfunction

    task automatic op8(input logic [7:0] xa, input logic [7:0] ya, input logic s, input logic ci,
                       output int lat, output int bcnt);
        @(negedge clk);
        x8 = xa; y8 = ya; sub8 = s; cin8 = ci; start8 = 1'b1;
        lat = 0; bcnt = 0;
        do begin
            @(negedge clk);
            start8 = 1'b0;
            lat++;
            if (busy8) bcnt++;
        end while (!done8 && lat < 64);
        if (!done8) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start8 = i[0];
            x8 = 8'h5A; y8 = 8'h33;
            n_cmp++;
            if ({z8, r8, ovf8, busy8, done8} !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_hold: z=%h r=%b ovf=%b busy=%b done=%b, required all 0",
                         z8, r8, ovf8, busy8, done8);
            end
        end
        start8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy=%b done=%b, required 0 0", busy8, done8);
        end
    endtask

    task automatic test_add();
        logic [7:0] tx [4] = '{8'h0F, 8'hFF, 8'h7F, 8'hFF};
        logic [7:0] ty [4] = '{8'h01, 8'h01, 8'h01, 8'hFF};
        logic       tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] ez [4] = '{8'h10, 8'h00, 8'h80, 8'hFF};
        logic       er [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic       eo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int lat, bcnt;
        for (int i = 0; i < 4; i++) begin
            op8(tx[i], ty[i], 1'b0, tc[i], lat, bcnt);
            n_cmp++;
            if (lat !== 9 || bcnt !== 8) begin
                n_fail++;
                $display("FAIL add_timing[%0d]: latency=%0d busy=%0d, required 9 8", i, lat, bcnt);
            end
            n_cmp++;
            if (z8 !== ez[i] || r8 !== er[i] || ovf8 !== eo[i]) begin
                n_fail++;
                $display("FAIL add_result[%0d]: z=%h r=%b ovf=%b, required z=%h r=%b ovf=%b",
                         i, z8, r8, ovf8, ez[i], er[i], eo[i]);
            end
        end
    endtask

    task automatic test_sub();
        logic [7:0] tx [3] = '{8'h05, 8'h80, 8'h10};
        logic [7:0] ty [3] = '{8'h07, 8'h01, 8'h01};
        logic       tc [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] ez [3] = '{8'hFE, 8'h7F, 8'h0E};
        logic       er [3] = '{1'b0, 1'b1, 1'b1};
        logic       eo [3] = '{1'b0, 1'b1, 1'b0};
        int lat, bcnt;
        for (int i = 0; i < 3; i++) begin
            op8(tx[i], ty[i], 1'b1, tc[i], lat, bcnt);
            n_cmp++;
            if (lat !== 9 || z8 !== ez[i] || r8 !== er[i] || ovf8 !== eo[i]) begin
                n_fail++;
                $display("FAIL sub_result[%0d]: lat=%0d z=%h r=%b ovf=%b, required lat=9 z=%h r=%b ovf=%b",
                         i, lat, z8, r8, ovf8, ez[i], er[i], eo[i]);
            end
        end
    endtask

    task automatic test_ignored_start();
        int lat = 0;
        int extra = 0;
        @(negedge clk);
        x8 = 8'h0F; y8 = 8'h01; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            start8 = (lat == 4);
            if (lat == 4) begin
                x8 = 8'hAA; y8 = 8'h55; sub8 = 1'b1; cin8 = 1'b1;
            end
        end while (!done8 && lat < 64);
        start8 = 1'b0;
        n_cmp++;
        if (lat !== 9 || z8 !== 8'h10 || r8 !== 1'b0 || ovf8 !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_start: lat=%0d z=%h r=%b ovf=%b, required lat=9 z=10 r=0 ovf=0",
                     lat, z8, r8, ovf8);
        end
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL ignored_start_no_second_op: active cycles=%0d, required 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] tx [3] = '{8'h0F, 8'h30, 8'hFF};
        logic [7:0] ty [3] = '{8'h01, 8'h05, 8'h01};
        logic [7:0] ez [3] = '{8'h10, 8'h35, 8'h00};
        logic       er [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] prev = 8'h00;
        int gap;
        @(negedge clk);
        x8 = tx[0]; y8 = ty[0]; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
                if (gap == 4 && i > 0) begin
                    n_cmp++;
                    if (z8 !== prev || busy8 !== 1'b1) begin
                        n_fail++;
                        $display("FAIL b2b_hold[%0d]: z=%h busy=%b, required z=%h busy=1",
                                 i, z8, busy8, prev);
                    end
                end
            end while (!done8 && gap < 64);
            n_cmp++;
            if (gap !== 9 || z8 !== ez[i] || r8 !== er[i]) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: gap=%0d z=%h r=%b, required gap=9 z=%h r=%b",
                         i, gap, z8, r8, ez[i], er[i]);
            end
            prev = ez[i];
            if (i < 2) begin
                x8 = tx[i+1]; y8 = ty[i+1];
            end else begin
                start8 = 1'b0;
            end
        end
        @(negedge clk);
        n_cmp++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_return_idle: busy=%b done=%b, required 0 0", busy8, done8);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, bcnt;
        @(negedge clk);
        x8 = 8'h0F; y8 = 8'h01; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || z8 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_op: busy=%b done=%b z=%h, required 0 0 00", busy8, done8, z8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        op8(8'h22, 8'h11, 1'b0, 1'b0, lat, bcnt);
        n_cmp++;
        if (lat !== 9 || z8 !== 8'h33 || r8 !== 1'b0 || ovf8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_recover: lat=%0d z=%h r=%b ovf=%b, required lat=9 z=33 r=0 ovf=0",
                     lat, z8, r8, ovf8);
        end
    endtask

    task automatic test_sweep_w1();
        longint ez;
        bit er, eo;
        int lat;
        for (int v = 0; v < 1000; v++) begin
            @(negedge clk);
            x1 = 1'($urandom_range(1)); y1 = 1'($urandom_range(1));
            sub1 = 1'($urandom_range(1)); cin1 = 1'($urandom_range(1));
            ref_model(1, longint'(x1), longint'(y1), sub1, cin1, ez, er, eo);
            start1 = 1'b1;
            lat = 0;
            do begin
                @(negedge clk);
                start1 = 1'b0;
                lat++;
            end while (!done1 && lat < 16);
            n_cmp++;
            if (!done1 || lat !== 2) begin
                n_fail++;
                $display("FAIL w1_latency[%0d]: lat=%0d done=%b, required 2", v, lat, done1);
            end
            n_cmp++;
            if (longint'(z1) !== ez || r1 !== er || ovf1 !== eo) begin
                n_fail++;
                $display("FAIL w1_result[%0d]: x=%h y=%h sub=%b cin=%b z=%h r=%b ovf=%b, required z=%0h r=%b ovf=%b",
                         v, x1, y1, sub1, cin1, z1, r1, ovf1, ez, er, eo);
            end
        end
    endtask

    task automatic test_sweep_w16();
        longint ez;
        bit er, eo;
        int lat;
        logic [31:0] rnd;
        for (int v = 0; v < 1000; v++) begin
            @(negedge clk);
            rnd = $urandom;
            x16 = rnd[15:0]; y16 = rnd[31:16];
            // Bias some vectors toward the signed/unsigned boundaries.
            if (v % 8 == 0) x16 = 16'h7FFF;
            if (v % 8 == 1) x16 = 16'h8000;
            if (v % 8 == 2) y16 = 16'hFFFF;
            sub16 = 1'($urandom_range(1)); cin16 = 1'($urandom_range(1));
            ref_model(16, longint'(x16), longint'(y16), sub16, cin16, ez, er, eo);
            start16 = 1'b1;
            lat = 0;
            do begin
                @(negedge clk);
                start16 = 1'b0;
                lat++;
            end while (!done16 && lat < 64);
            n_cmp++;
            if (!done16 || lat !== 17) begin
                n_fail++;
                $display("FAIL w16_latency[%0d]: lat=%0d done=%b, required 17", v, lat, done16);
            end
            n_cmp++;
            if (longint'(z16) !== ez || r16 !== er || ovf16 !== eo) begin
                n_fail++;
                $display("FAIL w16_result[%0d]: x=%h y=%h sub=%b cin=%b z=%h r=%b ovf=%b, required z=%0h r=%b ovf=%b",
                         v, x16, y16, sub16, cin16, z16, r16, ovf16, ez, er, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_op();
        test_sweep_w1();
        test_sweep_w16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
